// File: rtl/seq_divider.sv
// Sequential 32-bit signed restoring divider: one quotient bit per clock, IDLE/RUN/DONE control.
// Optional remainder output enabled by defining SEQ_DIVIDER_REMAINDER_EN.
module seq_divider (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic        ctrl_DIV,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY
`ifdef SEQ_DIVIDER_REMAINDER_EN
    ,
    output logic [31:0] data_remainder
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_r;
    logic [5:0]  count_r;
    logic [31:0] dividend_r;
    logic [31:0] divisor_r;
    logic [31:0] rem_r;
    logic [31:0] quo_r;
    logic        sign_a_r;
    logic        sign_b_r;
    logic        div0_r;
    logic        ovf_r;
`ifdef SEQ_DIVIDER_REMAINDER_EN
    logic [31:0] a_latched_r;
    logic [31:0] final_rem_s;
`endif

    logic [32:0] shifted_s;
    logic [32:0] diff_s;
    logic        qbit_s;
    logic [31:0] next_rem_s;
    logic [31:0] final_quo_s;

    // Unsigned magnitude; 0x80000000 maps to 2^31, which still fits in 32 unsigned bits.
    function automatic logic [31:0] magnitude(input logic [31:0] v);
        return v[31] ? (32'd0 - v) : v;
    endfunction

    // One restoring-division step plus sign restoration of the finished result.
    always_comb begin
        shifted_s   = {rem_r, dividend_r[31]};
        diff_s      = shifted_s - {1'b0, divisor_r};
        qbit_s      = ~diff_s[32];
        next_rem_s  = qbit_s ? diff_s[31:0] : shifted_s[31:0];
        final_quo_s = (sign_a_r ^ sign_b_r) ? (32'd0 - quo_r) : quo_r;
`ifdef SEQ_DIVIDER_REMAINDER_EN
        final_rem_s = sign_a_r ? (32'd0 - rem_r) : rem_r;
`endif
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r        <= IDLE;
            count_r        <= 6'd0;
            dividend_r     <= 32'd0;
            divisor_r      <= 32'd0;
            rem_r          <= 32'd0;
            quo_r          <= 32'd0;
            sign_a_r       <= 1'b0;
            sign_b_r       <= 1'b0;
            div0_r         <= 1'b0;
            ovf_r          <= 1'b0;
            data_result    <= 32'd0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
`ifdef SEQ_DIVIDER_REMAINDER_EN
            a_latched_r    <= 32'd0;
            data_remainder <= 32'd0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    data_resultRDY <= 1'b0;
                    if (ctrl_DIV) begin
                        sign_a_r   <= data_operandA[31];
                        sign_b_r   <= data_operandB[31];
                        dividend_r <= magnitude(data_operandA);
                        divisor_r  <= magnitude(data_operandB);
                        rem_r      <= 32'd0;
                        quo_r      <= 32'd0;
                        div0_r     <= (data_operandB == 32'd0);
                        ovf_r      <= (data_operandA == 32'h8000_0000) &&
                                      (data_operandB == 32'hFFFF_FFFF);
`ifdef SEQ_DIVIDER_REMAINDER_EN
                        a_latched_r <= data_operandA;
`endif
                        // A zero divisor skips the iterations and finishes on the following edge.
                        count_r    <= (data_operandB == 32'd0) ? 6'd32 : 6'd0;
                        state_r    <= RUN;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    if (count_r == 6'd32) begin
                        state_r        <= DONE;
                        data_resultRDY <= 1'b1;
                        if (div0_r) begin
                            data_result    <= 32'd0;
                            data_exception <= 1'b1;
`ifdef SEQ_DIVIDER_REMAINDER_EN
                            data_remainder <= a_latched_r;
`endif
                        end else begin
                            data_result    <= final_quo_s;
                            data_exception <= ovf_r;
`ifdef SEQ_DIVIDER_REMAINDER_EN
                            data_remainder <= final_rem_s;
`endif
                        end
                    end else begin
                        rem_r      <= next_rem_s;
                        quo_r      <= {quo_r[30:0], qbit_s};
                        dividend_r <= {dividend_r[30:0], 1'b0};
                        count_r    <= count_r + 6'd1;
                    end
                end
                DONE: begin
                    data_resultRDY <= 1'b0;
                    count_r        <= 6'd0;
                    state_r        <= IDLE;
                end
                default: begin
                    data_resultRDY <= 1'b0;
                    count_r        <= 6'd0;
                    state_r        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed vector table, multi-cycle corner sequences,
// and random operands checked against a plain-arithmetic reference model.
module tb_seq_divider;

    logic        clock;
    logic        reset;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        start;
    logic [31:0] res;
    logic        exc;
    logic        rdy;
`ifdef SEQ_DIVIDER_REMAINDER_EN
    logic [31:0] rem;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    seq_divider dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (opa),
        .data_operandB  (opb),
        .ctrl_DIV       (start),
        .data_result    (res),
        .data_exception (exc),
        .data_resultRDY (rdy)
`ifdef SEQ_DIVIDER_REMAINDER_EN
        ,
        .data_remainder (rem)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        e;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // Reference: signed 64-bit arithmetic truncates toward zero, remainder follows the dividend.
    task automatic model(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r, output logic e);
        longint sa;
        longint sb;
        longint lq;
        longint lr;
        if (b == 32'd0) begin
            q = 32'd0;
            r = a;
            e = 1'b1;
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            lq = sa / sb;
            lr = sa % sb;
            q  = lq[31:0];
            r  = lr[31:0];
            e  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        end
    endtask

    // Start at the next edge, scramble operands afterwards, wait a bounded time for RDY.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] q, output logic [31:0] r,
                           output logic e, output int lat);
        opa   = a;
        opb   = b;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        opa   = $urandom;
        opb   = $urandom;
        lat   = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clock);
            #1;
            if (rdy) begin
                lat = i;
                break;
            end
        end
        q = res;
        e = exc;
`ifdef SEQ_DIVIDER_REMAINDER_EN
        r = rem;
`else
        r = 32'd0;
`endif
        @(posedge clock);
        #1;
        check("rdy_one_cycle", {31'd0, rdy}, 32'd0);
    endtask

    task automatic apply(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er, input logic ee);
        logic [31:0] q;
        logic [31:0] r;
        logic        e;
        int          lat;
        run_div(a, b, q, r, e, lat);
        check({name, "_q"}, q, eq);
        check({name, "_exc"}, {31'd0, e}, {31'd0, ee});
        check({name, "_lat"}, lat, (b == 32'd0) ? 32'd1 : 32'd33);
`ifdef SEQ_DIVIDER_REMAINDER_EN
        check({name, "_rem"}, r, er);
`else
        if (r !== 32'd0) $display("note: remainder unexpectedly sampled (%0h)", er);
`endif
    endtask

    initial begin
        logic [31:0] mq;
        logic [31:0] mr;
        logic        me;
        logic [31:0] ra;
        logic [31:0] rb;
        int          lat;
        int          pulses;

        vecs[0]  = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
        vecs[1]  = '{32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0};
        vecs[2]  = '{32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  32'd2,          1'b0};
        vecs[3]  = '{32'd5,          32'd0,          32'd0,          32'd5,          1'b1};
        vecs[4]  = '{32'd9,          32'd3,          32'd3,          32'd0,          1'b0};
        vecs[5]  = '{32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b1};
        vecs[6]  = '{32'h8000_0000,  32'd1,          32'h8000_0000,  32'd0,          1'b0};
        vecs[7]  = '{32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF,  1'b0};
        vecs[8]  = '{32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          32'hFFFF_FFFF,  1'b0};
        vecs[9]  = '{32'h8000_0000,  32'h8000_0000,  32'd1,          32'd0,          1'b0};
        vecs[10] = '{32'h7FFF_FFFF,  32'h8000_0000,  32'd0,          32'h7FFF_FFFF,  1'b0};
        vecs[11] = '{32'd0,          32'hFFFF_FFFF,  32'd0,          32'd0,          1'b0};

        reset = 1'b1;
        start = 1'b0;
        opa   = 32'd0;
        opb   = 32'd0;
        repeat (2) @(posedge clock);
        #1;
        check("reset_result", res, 32'd0);
        check("reset_exc", {31'd0, exc}, 32'd0);
        check("reset_rdy", {31'd0, rdy}, 32'd0);
`ifdef SEQ_DIVIDER_REMAINDER_EN
        check("reset_rem", rem, 32'd0);
`endif
        reset = 1'b0;

        // First start lands on the first edge after reset release; vectors run back to back.
        for (int i = 0; i < 12; i++) begin
            apply($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].e);
        end

        // A second strobe during RUN must be ignored.
        opa   = 32'd50;
        opb   = 32'd5;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        lat   = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clock);
            #1;
            if (i == 9) begin
                start = 1'b1;
                opa   = 32'd8;
                opb   = 32'd2;
            end else begin
                start = 1'b0;
            end
            if (rdy) begin
                lat = i;
                break;
            end
        end
        start = 1'b0;
        check("ignore_start_q", res, 32'd10);
        check("ignore_start_lat", lat, 32'd33);
        @(posedge clock);
        #1;
        check("ignore_start_rdy_drop", {31'd0, rdy}, 32'd0);
        apply("back_to_back", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

        // Reset mid-operation: outputs clear at once and no RDY pulse follows.
        opa   = 32'd1000;
        opb   = 32'd10;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (15) @(posedge clock);
        reset = 1'b1;
        #1;
        check("abort_result", res, 32'd0);
        check("abort_exc", {31'd0, exc}, 32'd0);
        check("abort_rdy", {31'd0, rdy}, 32'd0);
`ifdef SEQ_DIVIDER_REMAINDER_EN
        check("abort_rem", rem, 32'd0);
`endif
        @(posedge clock);
        #1;
        reset  = 1'b0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1;
            if (rdy) pulses++;
        end
        check("abort_no_rdy", pulses, 32'd0);
        apply("after_abort", 32'd7, 32'd2, 32'd3, 32'd1, 1'b0);

        // Random operands against the reference model.
        for (int i = 0; i < 30; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 4))
                0: rb = $urandom_range(1, 15);
                1: rb = 32'd0 - $urandom_range(1, 15);
                2: rb = 32'd0;
                3: rb = $urandom >> $urandom_range(0, 31);
                default: rb = $urandom;
            endcase
            model(ra, rb, mq, mr, me);
            apply($sformatf("rand%0d", i), ra, rb, mq, mr, me);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
